// File: rtl/program_ctrl.sv
// Front-panel run controller: synchronises and debounces start/stop buttons and
// sequences a timed program (IDLE/RUN/PAUSE/DONE) that gates the blinker enable.
module program_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES  = 500_000,
  parameter int unsigned RUN_CYCLES       = 250_000_000,
  parameter int unsigned DONE_HOLD_CYCLES = 50_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_start,
  input  logic       btn_stop,
  output logic       main_program,
  output logic [1:0] state,
  output logic       done
);

  localparam int unsigned CNT_W     = 32;
  localparam int unsigned NUM_BTN   = 2;
  localparam int unsigned BTN_START = 0;
  localparam int unsigned BTN_STOP  = 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  logic [NUM_BTN-1:0]            btn_raw;
  logic [NUM_BTN-1:0]            s1;
  logic [NUM_BTN-1:0]            s2;
  logic [NUM_BTN-1:0]            deb;
  logic [NUM_BTN-1:0]            deb_d;
  logic [NUM_BTN-1:0][CNT_W-1:0] cnt;
  logic [NUM_BTN-1:0]            press_c;
  logic                          start_evt_c;
  logic                          stop_evt_c;

  state_t           state_q;
  state_t           state_d;
  logic [CNT_W-1:0] run_cnt;
  logic [CNT_W-1:0] run_cnt_d;
  logic [CNT_W-1:0] hold_cnt;
  logic [CNT_W-1:0] hold_cnt_d;

  assign btn_raw = {btn_stop, btn_start};

  // Per-button 2-flop synchroniser and stable-level debouncer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1    <= '0;
      s2    <= '0;
      deb   <= '0;
      deb_d <= '0;
      cnt   <= '0;
    end else begin
      s1    <= btn_raw;
      s2    <= s1;
      deb_d <= deb;
      for (int unsigned i = 0; i < NUM_BTN; i++) begin
        if (s2[i] == deb[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
          deb[i] <= s2[i];
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  // Rising-level press pulses; stop overrides a coincident start
  assign press_c     = deb & ~deb_d;
  assign stop_evt_c  = press_c[BTN_STOP];
  assign start_evt_c = press_c[BTN_START] & ~press_c[BTN_STOP];

  // run_cnt counts RUN cycles consumed, so the pausing RUN cycle is counted too
  always_comb begin
    state_d    = state_q;
    run_cnt_d  = run_cnt;
    hold_cnt_d = hold_cnt;
    case (state_q)
      ST_IDLE: begin
        if (start_evt_c) begin
          state_d   = ST_RUN;
          run_cnt_d = '0;
        end
      end
      ST_RUN: begin
        if (stop_evt_c) begin
          state_d   = ST_PAUSE;
          run_cnt_d = run_cnt + CNT_W'(1);
        end else if (run_cnt == CNT_W'(RUN_CYCLES - 1)) begin
          state_d    = ST_DONE;
          hold_cnt_d = '0;
        end else begin
          run_cnt_d = run_cnt + CNT_W'(1);
        end
      end
      ST_PAUSE: begin
        if (stop_evt_c) begin
          state_d   = ST_IDLE;
          run_cnt_d = '0;
        end else if (start_evt_c) begin
          // A pause on the very last RUN cycle leaves no budget to resume with
          state_d    = (run_cnt == CNT_W'(RUN_CYCLES)) ? ST_DONE : ST_RUN;
          hold_cnt_d = '0;
        end
      end
      ST_DONE: begin
        if (hold_cnt == CNT_W'(DONE_HOLD_CYCLES - 1)) begin
          state_d    = ST_IDLE;
          hold_cnt_d = '0;
        end else begin
          hold_cnt_d = hold_cnt + CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      run_cnt      <= '0;
      hold_cnt     <= '0;
      main_program <= 1'b0;
      done         <= 1'b0;
    end else begin
      state_q      <= state_d;
      run_cnt      <= run_cnt_d;
      hold_cnt     <= hold_cnt_d;
      main_program <= (state_d == ST_RUN);
      done         <= (state_d == ST_DONE) && (state_q != ST_DONE);
    end
  end

  assign state = state_q;

endmodule
